// File: rtl/dvp_pkg.sv
// Shared state encoding and default frame geometry for the DVP frame sequencer.
package dvp_pkg;

   typedef enum logic [2:0] {
      DVP_IDLE    = 3'd0,
      DVP_ARM     = 3'd1,
      DVP_WAIT_VS = 3'd2,
      DVP_FRAME   = 3'd3,
      DVP_CHECK   = 3'd4,
      DVP_STOP    = 3'd5
   } dvp_state_e;

   localparam int DVP_LINES        = 720;
   localparam int DVP_PIX_PER_LINE = 2560;
   localparam int DVP_FRAME_PERIOD = 4115952;
   // Roughly 2% above one nominal frame period.
   localparam int DVP_TIMEOUT_CYC  = 4200000;

   localparam int DVP_LINE_CNT_W = 11;
   localparam int DVP_PIX_CNT_W  = 13;

   function automatic int dvp_cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dvp_sync_monitor.sv
// Registers VSYNC/HREF, detects VSYNC rise and HREF fall, counts lines and pixels.
// The pixel counter and line-length compare exist only with DVP_SEQ_PIXCHK_EN.
module dvp_sync_monitor
   import dvp_pkg::*;
`ifdef DVP_SEQ_PIXCHK_EN
#(
   parameter int PIX_PER_LINE = DVP_PIX_PER_LINE
)
`endif
(
   input  logic                      pclk,
   input  logic                      reset_n,
   input  logic                      vsync,
   input  logic                      href,
   input  logic                      clr,
   output logic                      vs_rise,
   output logic                      href_fall,
   output logic [DVP_LINE_CNT_W-1:0] line_cnt,
   output logic                      pix_err
);

   logic vsync_reg, vsync_d_reg;
   logic href_reg, href_d_reg;
   logic [DVP_LINE_CNT_W-1:0] line_cnt_reg;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_reg   <= 1'b0;
         vsync_d_reg <= 1'b0;
         href_reg    <= 1'b0;
         href_d_reg  <= 1'b0;
      end else begin
         vsync_reg   <= vsync;
         vsync_d_reg <= vsync_reg;
         href_reg    <= href;
         href_d_reg  <= href_reg;
      end
   end

   assign vs_rise   = vsync_reg & ~vsync_d_reg;
   assign href_fall = ~href_reg & href_d_reg;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         line_cnt_reg <= '0;
      end else if (clr) begin
         line_cnt_reg <= '0;
      end else if (href_fall && (line_cnt_reg != '1)) begin
         line_cnt_reg <= line_cnt_reg + 1'b1;
      end
   end

   assign line_cnt = line_cnt_reg;

`ifdef DVP_SEQ_PIXCHK_EN
   localparam logic [DVP_PIX_CNT_W-1:0] PIX_LEN = DVP_PIX_CNT_W'(PIX_PER_LINE);

   logic [DVP_PIX_CNT_W-1:0] pix_cnt_reg;
   logic                     pix_err_reg;

   // The fall cycle has href_reg low, so compare and count never collide.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         pix_cnt_reg <= '0;
         pix_err_reg <= 1'b0;
      end else if (clr) begin
         pix_cnt_reg <= '0;
         pix_err_reg <= 1'b0;
      end else if (href_fall) begin
         pix_cnt_reg <= '0;
         if (pix_cnt_reg != PIX_LEN) begin
            pix_err_reg <= 1'b1;
         end
      end else if (href_reg && (pix_cnt_reg != '1)) begin
         pix_cnt_reg <= pix_cnt_reg + 1'b1;
      end
   end

   assign pix_err = pix_err_reg;
`else
   assign pix_err = 1'b0;
`endif

endmodule

// File: rtl/dvp_frame_sequencer.sv
// HDR capture sequencer: drives start/stop pulses to a DVP source and checks frame geometry.
// Optional per-line pixel check is built when DVP_SEQ_PIXCHK_EN is defined.
module dvp_frame_sequencer
   import dvp_pkg::*;
#(
   parameter int LINES_PER_FRAME = DVP_LINES,
   parameter int PIX_PER_LINE    = DVP_PIX_PER_LINE,
   parameter int TIMEOUT_CYC     = DVP_TIMEOUT_CYC,
   parameter int FCNT_W          = 6
)(
   input  logic              pclk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [FCNT_W-1:0] num_frames,
   input  logic              vsync,
   input  logic              href,
   output logic              run_test,
   output logic              stop_test,
   output logic              busy,
   output logic              exp_sel,
   output logic              frame_done,
   output logic              frame_ok,
   output logic [FCNT_W-1:0] frames_done,
   output logic              err_lines,
   output logic              err_pixels,
   output logic              err_timeout
);

   localparam logic [2:0] ST_IDLE    = DVP_IDLE;
   localparam logic [2:0] ST_ARM     = DVP_ARM;
   localparam logic [2:0] ST_WAIT_VS = DVP_WAIT_VS;
   localparam logic [2:0] ST_FRAME   = DVP_FRAME;
   localparam logic [2:0] ST_CHECK   = DVP_CHECK;
   localparam logic [2:0] ST_STOP    = DVP_STOP;

   localparam int                        TMO_W     = dvp_cnt_width(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0]          TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [DVP_LINE_CNT_W-1:0] LINE_LAST = DVP_LINE_CNT_W'(LINES_PER_FRAME - 1);

   logic [2:0]                state_reg, state_next;
   logic [TMO_W-1:0]          tmo_cnt_reg;
   logic [FCNT_W-1:0]         frames_done_reg, num_frames_reg, frames_inc;
   logic                      exp_sel_reg, short_reg;
   logic                      err_lines_reg, err_timeout_reg;

   logic                      vs_rise, href_fall, pix_err;
   logic [DVP_LINE_CNT_W-1:0] line_cnt;
   logic                      start_acc, line_last, timed, tmo_hit, run_done, short_det;

   // Counters are held clear outside FRAME, so every entry to FRAME starts from zero.
`ifdef DVP_SEQ_PIXCHK_EN
   dvp_sync_monitor #(
      .PIX_PER_LINE (PIX_PER_LINE)
   ) u_sync_monitor (
`else
   dvp_sync_monitor u_sync_monitor (
`endif
      .pclk      (pclk),
      .reset_n   (reset_n),
      .vsync     (vsync),
      .href      (href),
      .clr       (state_reg != ST_FRAME),
      .vs_rise   (vs_rise),
      .href_fall (href_fall),
      .line_cnt  (line_cnt),
      .pix_err   (pix_err)
   );

   assign start_acc  = (state_reg == ST_IDLE) && start && !abort;
   assign line_last  = href_fall && (line_cnt == LINE_LAST);
   assign timed      = (state_reg == ST_WAIT_VS) || (state_reg == ST_FRAME);
   assign tmo_hit    = timed && (tmo_cnt_reg == TMO_LAST);
   assign frames_inc = frames_done_reg + 1'b1;
   assign run_done   = (num_frames_reg != '0) && (frames_inc == num_frames_reg);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_acc) state_next = ST_ARM;
         end
         ST_ARM: begin
            state_next = abort ? ST_STOP : ST_WAIT_VS;
         end
         ST_WAIT_VS: begin
            if (abort || tmo_hit) state_next = ST_STOP;
            else if (vs_rise)     state_next = ST_FRAME;
         end
         ST_FRAME: begin
            // A VSYNC rise before the last line ends a short frame.
            if (abort || tmo_hit)         state_next = ST_STOP;
            else if (line_last || vs_rise) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (abort || run_done) state_next = ST_STOP;
            else if (short_reg)    state_next = ST_FRAME;
            else                   state_next = ST_WAIT_VS;
         end
         ST_STOP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign short_det = (state_reg == ST_FRAME) && (state_next == ST_CHECK) && !line_last;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= ST_IDLE;
         tmo_cnt_reg     <= '0;
         frames_done_reg <= '0;
         num_frames_reg  <= '0;
         exp_sel_reg     <= 1'b0;
         short_reg       <= 1'b0;
         err_lines_reg   <= 1'b0;
         err_timeout_reg <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (state_next != state_reg) begin
            tmo_cnt_reg <= '0;
         end else if (timed) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
         end

         if (start_acc) begin
            frames_done_reg <= '0;
            num_frames_reg  <= num_frames;
            exp_sel_reg     <= 1'b0;
            err_lines_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
         end

         if (state_reg == ST_FRAME) begin
            short_reg <= short_det;
         end
         if (short_det) begin
            err_lines_reg <= 1'b1;
         end
         if (tmo_hit) begin
            err_timeout_reg <= 1'b1;
         end

         if (state_reg == ST_CHECK) begin
            frames_done_reg <= frames_inc;
            exp_sel_reg     <= ~exp_sel_reg;
         end
      end
   end

`ifdef DVP_SEQ_PIXCHK_EN
   logic err_pixels_reg;

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         err_pixels_reg <= 1'b0;
      end else if (start_acc) begin
         err_pixels_reg <= 1'b0;
      end else if ((state_reg == ST_CHECK) && pix_err) begin
         err_pixels_reg <= 1'b1;
      end
   end

   assign err_pixels = err_pixels_reg;
`else
   assign err_pixels = 1'b0;
   // Line length is accepted for interface compatibility but not measured here.
   if (PIX_PER_LINE < 1) begin : g_pix_len_unused
   end
`endif

   assign run_test    = (state_reg == ST_ARM);
   assign stop_test   = (state_reg == ST_STOP);
   assign busy        = (state_reg != ST_IDLE);
   assign frame_done  = (state_reg == ST_CHECK);
   assign frame_ok    = frame_done && !short_reg && !pix_err;
   assign exp_sel     = exp_sel_reg;
   assign frames_done = frames_done_reg;
   assign err_lines   = err_lines_reg;
   assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_dvp_frame_sequencer.sv
// Scoreboard bench for dvp_frame_sequencer using a reduced frame geometry.
module tb_dvp_frame_sequencer;

   localparam int LINES  = 8;
   localparam int PIX    = 16;
   localparam int TMO    = 300;
   localparam int FCNT_W = 6;
`ifdef DVP_SEQ_PIXCHK_EN
   localparam logic PIXCHK = 1'b1;
`else
   localparam logic PIXCHK = 1'b0;
`endif

   logic              pclk = 1'b0;
   logic              reset_n, start, abort, vsync, href;
   logic [FCNT_W-1:0] num_frames;
   logic              run_test, stop_test, busy, exp_sel, frame_done, frame_ok;
   logic [FCNT_W-1:0] frames_done;
   logic              err_lines, err_pixels, err_timeout;

   typedef struct {
      logic              ok;
      logic              sel;
      logic [FCNT_W-1:0] fd;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              exp_item;
   logic              model_sel;
   logic [FCNT_W-1:0] model_fd;
   int                n_checks = 0;
   int                n_errors = 0;
   int                run_cnt = 0, stop_cnt = 0, fd_cnt = 0;
   int                run0, stop0, fd0;

   always #5 pclk = ~pclk;

   dvp_frame_sequencer #(
      .LINES_PER_FRAME (LINES),
      .PIX_PER_LINE    (PIX),
      .TIMEOUT_CYC     (TMO),
      .FCNT_W          (FCNT_W)
   ) dut (
      .pclk        (pclk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .num_frames  (num_frames),
      .vsync       (vsync),
      .href        (href),
      .run_test    (run_test),
      .stop_test   (stop_test),
      .busy        (busy),
      .exp_sel     (exp_sel),
      .frame_done  (frame_done),
      .frame_ok    (frame_ok),
      .frames_done (frames_done),
      .err_lines   (err_lines),
      .err_pixels  (err_pixels),
      .err_timeout (err_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   always @(negedge pclk) begin
      if (reset_n) begin
         if (run_test)  run_cnt++;
         if (stop_test) stop_cnt++;
         if (frame_done) begin
            fd_cnt++;
            $display("frame_done ok=%0b exp_sel=%0b frames_done=%0d", frame_ok, exp_sel, frames_done);
            if (exp_q.size() == 0) begin
               check("frame_done_unexpected", {31'd0, frame_done}, 32'd0);
            end else begin
               exp_item = exp_q.pop_front();
               check("frame_ok", {31'd0, frame_ok}, {31'd0, exp_item.ok});
               check("exp_sel", {31'd0, exp_sel}, {31'd0, exp_item.sel});
               check("frames_done_at_pulse", 32'(frames_done), 32'(exp_item.fd));
            end
         end
      end
   end

   task automatic expect_frame(input logic ok);
      exp_t e;
      e.ok  = ok;
      e.sel = model_sel;
      e.fd  = model_fd;
      exp_q.push_back(e);
      model_sel = ~model_sel;
      model_fd  = model_fd + 1'b1;
   endtask

   task automatic start_run(input int nf);
      num_frames = FCNT_W'(nf);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      model_sel = 1'b0;
      model_fd  = '0;
      @(negedge pclk);
      check("run_test_pulse", {31'd0, run_test}, 32'd1);
      cyc(1);
   endtask

   // odd_line gets odd_len HREF cycles; poke_line pulses start mid-line.
   task automatic send_frame(input int lines, input int odd_line, input int odd_len, input int poke_line);
      vsync = 1'b1;
      cyc(3);
      vsync = 1'b0;
      cyc(4);
      for (int i = 0; i < lines; i++) begin
         int len;
         len  = (i == odd_line) ? odd_len : PIX;
         href = 1'b1;
         for (int p = 0; p < len; p++) begin
            start = (i == poke_line) && (p == 5);
            cyc(1);
         end
         start = 1'b0;
         href  = 1'b0;
         cyc(5);
      end
      cyc(6);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin
         cyc(1);
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; num_frames = '0;
      vsync = 1'b0; href = 1'b0; model_sel = 1'b0; model_fd = '0;
      cyc(3);
      @(negedge pclk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_run_test", {31'd0, run_test}, 32'd0);
      check("rst_stop_test", {31'd0, stop_test}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_frames_done", 32'(frames_done), 32'd0);
      check("rst_errors", {29'd0, err_lines, err_pixels, err_timeout}, 32'd0);
      @(posedge pclk);
      #1 reset_n = 1'b1;
      cyc(2);

      // Two nominal frames
      stop0 = stop_cnt; fd0 = fd_cnt;
      start_run(2);
      expect_frame(1'b1); send_frame(LINES, -1, 0, -1);
      expect_frame(1'b1); send_frame(LINES, -1, 0, -1);
      wait_idle("nom_idle");
      check("nom_frame_count", 32'(fd_cnt - fd0), 32'd2);
      check("nom_frames_done", 32'(frames_done), 32'd2);
      check("nom_stop_count", 32'(stop_cnt - stop0), 32'd1);
      check("nom_errors", {29'd0, err_lines, err_pixels, err_timeout}, 32'd0);
      check("nom_exp_sel_end", {31'd0, exp_sel}, {31'd0, model_sel});

      // Short frame followed by a frame counted from its VSYNC
      start_run(2);
      expect_frame(1'b0); send_frame(LINES - 1, -1, 0, -1);
      expect_frame(1'b1); send_frame(LINES, -1, 0, -1);
      wait_idle("short_idle");
      check("short_err_lines", {31'd0, err_lines}, 32'd1);
      check("short_frames_done", 32'(frames_done), 32'd2);

      // One short line in the first frame only
      start_run(2);
      check("start_clears_err_lines", {31'd0, err_lines}, 32'd0);
      expect_frame(~PIXCHK); send_frame(LINES, 3, PIX - 1, -1);
      expect_frame(1'b1);    send_frame(LINES, -1, 0, -1);
      wait_idle("pix_idle");
      check("pix_err_pixels", {31'd0, err_pixels}, {31'd0, PIXCHK});
      check("pix_err_lines", {31'd0, err_lines}, 32'd0);

      // No VSYNC at all: timeout
      fd0 = fd_cnt;
      num_frames = FCNT_W'(1);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      @(negedge pclk);
      check("tmo_run_test", {31'd0, run_test}, 32'd1);
      n = 0;
      do begin
         @(negedge pclk);
         n++;
      end while (!stop_test && n < 4 * TMO);
      check("tmo_stop_latency", 32'(n), 32'(TMO + 1));
      check("tmo_err_timeout", {31'd0, err_timeout}, 32'd1);
      @(negedge pclk);
      check("tmo_busy_low", {31'd0, busy}, 32'd0);
      check("tmo_no_frame_done", 32'(fd_cnt - fd0), 32'd0);

      // Continuous mode, abort part way through the second frame
      cyc(1);
      start_run(0);
      expect_frame(1'b1); send_frame(LINES, -1, 0, -1);
      fd0 = fd_cnt;
      send_frame(LINES / 2, -1, 0, -1);
      href = 1'b1;
      cyc(5);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      href  = 1'b0;
      @(negedge pclk);
      check("abort_stop_test", {31'd0, stop_test}, 32'd1);
      @(negedge pclk);
      check("abort_busy_low", {31'd0, busy}, 32'd0);
      check("abort_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
      check("abort_frames_done", 32'(frames_done), 32'd1);

      // start and abort together in IDLE
      cyc(1);
      run0 = run_cnt;
      start = 1'b1; abort = 1'b1;
      cyc(1);
      start = 1'b0; abort = 1'b0;
      @(negedge pclk);
      check("start_abort_run_test", {31'd0, run_test}, 32'd0);
      check("start_abort_busy", {31'd0, busy}, 32'd0);

      // start during FRAME is ignored
      cyc(1);
      run0 = run_cnt;
      start_run(1);
      expect_frame(1'b1); send_frame(LINES, -1, 0, 2);
      wait_idle("busy_start_idle");
      check("busy_start_runs", 32'(run_cnt - run0), 32'd1);
      check("busy_start_frames_done", 32'(frames_done), 32'd1);

      // Reset in the middle of a run
      stop0 = stop_cnt;
      start_run(0);
      cyc(3);
      reset_n = 1'b0;
      @(negedge pclk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_stop_test", {31'd0, stop_test}, 32'd0);
      cyc(1);
      reset_n = 1'b1;
      cyc(3);
      check("midrst_no_stop", 32'(stop_cnt - stop0), 32'd0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
